// File: rtl/belt_frames.sv
// Belt operand store: circular belt of DEPTH entries with two drop lanes per
// cycle, two registered read ports addressed by belt position, and a hardware
// frame stack that saves/restores {idx,count} across call (mark) and return
// (rewind). Return values dropped in the rewind cycle land on the caller's belt.
module belt_frames #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int FRAMES = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int FW    = $clog2(FRAMES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drop0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             drop1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic [AW-1:0]    r1,
  output logic [WIDTH-1:0] rdata1,
  output logic             rvalid1,
  input  logic [AW-1:0]    r2,
  output logic [WIDTH-1:0] rdata2,
  output logic             rvalid2,
  input  logic             mark,
  input  logic             rewind,
  input  logic             clr_err,
  output logic [AW:0]      count,
  output logic [FW-1:0]    frame_depth,
  output logic             frame_ovf,
  output logic             frame_unf
);

  // Index width into the frame stack storage (at least one bit).
  localparam int SW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  // Belt storage and frame stack storage; neither is reset. Stack slots at or
  // above frame_depth are never read, so their contents do not matter.
  logic [WIDTH-1:0] belt    [DEPTH];
  logic [AW-1:0]    stk_idx [FRAMES];
  logic [AW:0]      stk_cnt [FRAMES];

  // Position of the next drop (the slot just past the newest entry).
  logic [AW-1:0]    idx;

  logic [1:0]       ndrops;
  logic             stk_empty;
  logic             stk_full;
  logic             do_pop;
  logic             do_push;
  logic             err_ovf;
  logic             err_unf;
  logic [SW-1:0]    top_sel;
  logic [SW-1:0]    push_sel;
  logic [AW-1:0]    base_idx_p0;
  logic [AW:0]      base_cnt_p0;
  logic [AW-1:0]    idx_next;
  logic [AW+1:0]    cnt_sum;
  logic [AW:0]      count_next;
  logic [AW-1:0]    wa0_p0;
  logic [AW-1:0]    wa1_p0;
  logic [WIDTH-1:0] wd0_p0;
  logic             we0_p0;
  logic             we1_p0;
  logic [AW-1:0]    ra1_p0;
  logic [AW-1:0]    ra2_p0;

  // Next-state decode: frame stack action, drop base, write ports, read addresses.
  always_comb begin
    ndrops    = {1'b0, drop0} + {1'b0, drop1};
    stk_empty = (frame_depth == '0);
    stk_full  = (frame_depth == FW'(FRAMES));

    // Rewind has priority over mark; a mark alongside a rewind is dropped silently.
    do_pop    = rewind & ~stk_empty;
    err_unf   = rewind & stk_empty;
    do_push   = mark & ~rewind & ~stk_full;
    err_ovf   = mark & ~rewind & stk_full;

    top_sel   = SW'(frame_depth - FW'(1));
    push_sel  = SW'(frame_depth);

    // On a successful return the drops land relative to the caller's saved
    // position, discarding everything the callee left on the belt.
    base_idx_p0 = do_pop ? stk_idx[top_sel] : idx;
    base_cnt_p0 = do_pop ? stk_cnt[top_sel] : count;

    idx_next   = base_idx_p0 + AW'(ndrops);
    cnt_sum    = {1'b0, base_cnt_p0} + (AW+2)'(ndrops);
    count_next = (cnt_sum > (AW+2)'(DEPTH)) ? (AW+1)'(DEPTH) : cnt_sum[AW:0];

    // Lane 0 is the older result, so it takes the lower slot when both drop;
    // a lone lane-1 drop uses the lower slot too.
    we0_p0 = drop0 | drop1;
    we1_p0 = drop0 & drop1;
    wd0_p0 = drop0 ? wdata0 : wdata1;
    wa0_p0 = base_idx_p0;
    wa1_p0 = base_idx_p0 + AW'(1);

    // Position 0 is the newest entry, one slot behind idx.
    ra1_p0 = idx - r1 - AW'(1);
    ra2_p0 = idx - r2 - AW'(1);
  end

  // Belt array writes from the two drop lanes.
  always_ff @(posedge clk) begin
    if (we0_p0) belt[wa0_p0] <= wd0_p0;
    if (we1_p0) belt[wa1_p0] <= wdata1;
  end

  // Frame stack push of the pre-edge belt position.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stk_idx[push_sel] <= idx;
      stk_cnt[push_sel] <= count;
    end
  end

  // Belt position, live count, frame depth and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      count       <= '0;
      frame_depth <= '0;
      frame_ovf   <= 1'b0;
      frame_unf   <= 1'b0;
    end else begin
      idx   <= idx_next;
      count <= count_next;
      if (do_pop) begin
        frame_depth <= frame_depth - FW'(1);
      end else if (do_push) begin
        frame_depth <= frame_depth + FW'(1);
      end
      // A new error in the same cycle as clr_err keeps the flag set.
      frame_ovf <= err_ovf | (frame_ovf & ~clr_err);
      frame_unf <= err_unf | (frame_unf & ~clr_err);
    end
  end

  // Registered read ports, using pre-edge idx/count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata1  <= '0;
      rdata2  <= '0;
      rvalid1 <= 1'b0;
      rvalid2 <= 1'b0;
    end else begin
      rdata1  <= belt[ra1_p0];
      rdata2  <= belt[ra2_p0];
      rvalid1 <= ({1'b0, r1} < count);
      rvalid2 <= ({1'b0, r2} < count);
    end
  end

endmodule

// File: doc/belt_frames.md
Name: belt_frames

Overview:
- Next-generation belt operand store for the belt-machine CPU.
- Parametrised width/depth circular belt.
- Two drop lanes per cycle, so one instruction can retire two results.
- Per-entry validity tracking.
- Hardware frame stack: call (mark) / return (rewind) discards callee belt entries and restores the caller's belt position. Return values dropped in the same cycle land on the caller's belt.

Parameters:
- WIDTH, 32, data width of each belt entry.
- DEPTH, 16, belt entries; power of two, >=4. AW = log2(DEPTH).
- FRAMES, 4, frame-stack entries; >=1. FW = ceil(log2(FRAMES+1)).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- drop0  in  1  drop lane 0 (older result).
- wdata0  in  WIDTH  lane 0 data.
- drop1  in  1  drop lane 1 (younger result).
- wdata1  in  WIDTH  lane 1 data.
- r1  in  AW  read position, port 1 (0 = newest).
- rdata1  out  WIDTH  registered read data, port 1.
- rvalid1  out  1  registered: position r1 held a live entry.
- r2  in  AW  read position, port 2.
- rdata2  out  WIDTH  registered read data, port 2.
- rvalid2  out  1  registered validity, port 2.
- mark  in  1  push current {idx,count} onto frame stack.
- rewind  in  1  pop frame stack; restore {idx,count}.
- clr_err  in  1  clear sticky error flags.
- count  out  AW+1  live entries, saturating at DEPTH.
- frame_depth  out  FW  frames currently pushed.
- frame_ovf  out  1  sticky: mark while stack full.
- frame_unf  out  1  sticky: rewind while stack empty.

Behaviour:
- Reset (rst=0, async):
  - idx=0, count=0, frame_depth=0, frame_ovf=0, frame_unf=0.
  - rdata1/2=0, rvalid1/2=0.
  - Belt array contents are not reset.
  - Deassertion is synchronous to clk.
- Reads:
  - One-cycle latency. At each edge, rdataN <= belt[(idx - rN - 1) mod DEPTH] and rvalidN <= (rN < count).
  - Reads use pre-edge idx/count, so drops in the same cycle are not visible until the following cycle.
  - An invalid position returns stale array data with rvalid=0.
- Drop, ndrops = drop0+drop1:
  - Both set: belt[idx]<=wdata0, belt[idx+1]<=wdata1, idx+=2. wdata1 becomes position 0 and wdata0 position 1.
  - Single drop on either lane: belt[idx]<=that lane's data, idx+=1.
  - count <= min(count+ndrops, DEPTH).
  - idx wraps mod DEPTH. The oldest entries are silently overwritten once full.
- mark (rewind=0):
  - Stack not full: push pre-edge {idx,count}; frame_depth+=1.
  - Stack full: no push; frame_ovf<=1.
  - Drops in the same cycle apply normally and belong to the new frame.
- rewind:
  - Stack not empty: pop {sidx,scount}. Any same-cycle drops are written at sidx, sidx+1. idx <= sidx+ndrops; count <= min(scount+ndrops, DEPTH); frame_depth-=1.
  - Stack empty: frame_unf<=1; idx/count update as for plain drops.
- mark and rewind in the same cycle: rewind takes effect and mark is ignored. No error flag is raised.
- clr_err: clears both sticky flags next edge. If an error condition occurs in the same cycle, set wins.
- Frame entries beyond overwritten data are not tracked. After a callee overwrites caller entries (wrap), the restored values are whatever the array now holds; this is documented software-visible behaviour.
- Reset mid-operation discards all frames immediately.

Test Plan:
- Reset, single drops 0x11, 0x22, 0x33; read r1=0, r2=2 -> next cycle rdata1=0x33, rdata2=0x11, rvalid1=rvalid2=1; r1=3 -> rvalid1=0; count=3.
- Dual drop wdata0=0xA, wdata1=0xB in one cycle; read r1=0, r2=1 next cycle -> 0xB, 0xA; count+=2. Same-cycle read of r1=0 still returns the prior newest value.
- DEPTH+3 single drops of values 1..DEPTH+3 -> count=DEPTH (saturated); r1=DEPTH-1 returns 4 with rvalid=1; idx wraps correctly.
- After drops 0x1, 0x2: mark; then drops 0x5, 0x6, 0x7; then rewind with drop0=0x99 -> count=3; r1=0 gives 0x99, r1=1 gives 0x2; frame_depth back to 0.
- FRAMES+1 marks -> frame_depth=FRAMES, frame_ovf=1. Then FRAMES+1 rewinds -> frame_depth=0, frame_unf=1. Then clr_err -> both flags 0.
- Assert rst=0 asynchronously mid-stream, between edges, with frames pushed -> count, frame_depth, rvalid and flags read 0 immediately without waiting for a clock edge.
